// File: rtl/pos_ring_node_router_fifo_pkg.sv
// Shared widths, injection constants and packet field helpers for the
// position-ring node router.
package pos_ring_node_router_fifo_pkg;

  localparam int DEF_OFFSET_W        = 23;
  localparam int DEF_CELL_ID_W       = 3;
  localparam int DEF_GCID_W          = 2;
  localparam int DEF_ELEMENT_W       = 2;
  localparam int DEF_PID_W           = 8;
  localparam int DEF_LIFETIME_W      = 4;
  localparam int DEF_INJECT_LIFETIME = 12;
  localparam int DEF_LOCAL_CID       = 2;
  localparam int DEF_FIFO_DEPTH      = 16;
  localparam int DEF_AF_MARGIN       = 4;
  localparam int DEF_CNT_W           = 16;

  // Ring packet width: {pid, elem, z_off, y_off, x_off}
  function automatic int pkt_w(int off_w, int elem_w, int pid_w);
    return 3 * off_w + elem_w + pid_w;
  endfunction

  // PE packet width: {pid, elem, {cid,z_off}, {cid,y_off}, {cid,x_off}}
  function automatic int pos_w(int cid_w, int off_w, int elem_w, int pid_w);
    return 3 * (cid_w + off_w) + elem_w + pid_w;
  endfunction

  // LSB of the offset of a given axis (0=x, 1=y, 2=z) inside a ring packet
  function automatic int axis_lsb(int axis, int off_w);
    return axis * off_w;
  endfunction

  localparam int DEF_PKT_W = pkt_w(DEF_OFFSET_W, DEF_ELEMENT_W, DEF_PID_W);
  localparam int DEF_POS_W = pos_w(DEF_CELL_ID_W, DEF_OFFSET_W, DEF_ELEMENT_W, DEF_PID_W);

endpackage

// File: rtl/pos_ring_node_router_fifo_if.sv
// Handshake bundle between the router and its neighbours: the pos-cache
// injection channel and the PE delivery channel.
//
// Handshake rule (both channels): a transfer happens on a rising clk edge
// where valid & ready are both 1. The producer holds data stable while valid
// is high and not yet accepted; ready may depend combinationally on state and
// other inputs but never on the data lines.
interface pos_ring_node_router_fifo_if #(
  parameter int PKT_W   = pos_ring_node_router_fifo_pkg::DEF_PKT_W,
  parameter int GCID3_W = 3 * pos_ring_node_router_fifo_pkg::DEF_GCID_W,
  parameter int POS_W   = pos_ring_node_router_fifo_pkg::DEF_POS_W
);
  // injection channel (pos cache -> router)
  logic [PKT_W-1:0]   local_offset_pkt;
  logic [GCID3_W-1:0] local_gcid;
  logic               local_valid;
  logic               local_ready;
  // delivery channel (router -> PE)
  logic [POS_W-1:0]   pos_pkt_to_pe;
  logic               pos_pkt_to_pe_valid;
  logic               pe_ready;

  // environment side: pos cache producer and PE consumer
  modport master (
    output local_offset_pkt, local_gcid, local_valid, pe_ready,
    input  local_ready, pos_pkt_to_pe, pos_pkt_to_pe_valid
  );

  // router side
  modport slave (
    input  local_offset_pkt, local_gcid, local_valid, pe_ready,
    output local_ready, pos_pkt_to_pe, pos_pkt_to_pe_valid
  );
endinterface

// File: rtl/pos_ring_node_router_fifo_pe_fifo.sv
// Synchronous first-word-fall-through FIFO feeding the PE. The head entry is
// presented combinationally; an empty FIFO presents all zeros so the PE bus
// is quiet after reset. Push while full succeeds only alongside a pop.
module pos_pe_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             valid,
  output logic             full,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             empty;
  logic             pop_ok;
  logic             push_ok;

  // status and accepted-operation qualification
  always_comb begin
    empty    = (count == '0);
    full     = (count == (AW+1)'(DEPTH));
    valid    = ~empty;
    pop_ok   = pop & ~empty;
    push_ok  = push & (~full | pop_ok);
    pop_data = empty ? '0 : mem[rd_ptr];
  end

  // storage write; contents need no reset since count gates visibility
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  // pointers wrap naturally at DEPTH (power of two); count tracks occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/pos_ring_node_router_fifo.sv
// Position-ring node router: forwards live ring slots (decrementing lifetime
// on a hit), injects pos-cache packets into empty slots, and queues hit or
// injected packets for the PE with cell ids attached.
module pos_ring_node_router_fifo
  import pos_ring_node_router_fifo_pkg::*;
#(
  parameter int OFFSET_W        = DEF_OFFSET_W,
  parameter int CELL_ID_W       = DEF_CELL_ID_W,
  parameter int GCID_W          = DEF_GCID_W,
  parameter int ELEMENT_W       = DEF_ELEMENT_W,
  parameter int PID_W           = DEF_PID_W,
  parameter int LIFETIME_W      = DEF_LIFETIME_W,
  parameter int INJECT_LIFETIME = DEF_INJECT_LIFETIME,
  parameter int LOCAL_CID       = DEF_LOCAL_CID,
  parameter int FIFO_DEPTH      = DEF_FIFO_DEPTH,
  parameter int AF_MARGIN       = DEF_AF_MARGIN,
  parameter int CNT_W           = DEF_CNT_W,
  localparam int PKT_W          = pkt_w(OFFSET_W, ELEMENT_W, PID_W),
  localparam int POS_W          = pos_w(CELL_ID_W, OFFSET_W, ELEMENT_W, PID_W),
  localparam int CNT_FW         = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_hit,
  input  logic                  i_dispatcher_back_pressure,
  input  logic                  i_inject_en,
  input  logic [PKT_W-1:0]      i_source_offset_pkt,
  input  logic [3*GCID_W-1:0]   i_source_gcid,
  input  logic [LIFETIME_W-1:0] i_source_lifetime,
  input  logic [CELL_ID_W-1:0]  i_cid_x,
  input  logic [CELL_ID_W-1:0]  i_cid_y,
  input  logic [CELL_ID_W-1:0]  i_cid_z,
  pos_ring_node_router_fifo_if.slave bus,
  output logic [PKT_W-1:0]      o_offset_pkt_to_ring,
  output logic [3*GCID_W-1:0]   o_gcid_to_ring,
  output logic [LIFETIME_W-1:0] o_lifetime_to_ring,
  output logic [CNT_FW-1:0]     o_fifo_count,
  output logic [CNT_W-1:0]      o_hit_count,
  output logic [CNT_W-1:0]      o_drop_count,
  output logic                  o_overflow
);

  localparam int TAIL_W = ELEMENT_W + PID_W;
  localparam logic [CELL_ID_W-1:0] LCID = CELL_ID_W'(LOCAL_CID);

  // Re-pack a ring packet for the PE, inserting a cell id above each offset.
  function automatic logic [POS_W-1:0] make_pos(
    input logic [PKT_W-1:0]     p,
    input logic [CELL_ID_W-1:0] cx,
    input logic [CELL_ID_W-1:0] cy,
    input logic [CELL_ID_W-1:0] cz
  );
    logic [TAIL_W-1:0]   tail;
    logic [OFFSET_W-1:0] ox, oy, oz;
    tail = p[PKT_W-1 -: TAIL_W];
    ox   = p[axis_lsb(0, OFFSET_W) +: OFFSET_W];
    oy   = p[axis_lsb(1, OFFSET_W) +: OFFSET_W];
    oz   = p[axis_lsb(2, OFFSET_W) +: OFFSET_W];
    return {tail, cz, oz, cy, oy, cx, ox};
  endfunction

  logic              slot_live;
  logic              inject_room;
  logic              local_ready;
  logic              accept;
  logic              hit_push;
  logic              push;
  logic              pop;
  logic              drop;
  logic              fifo_full;
  logic [POS_W-1:0]  push_data;
  logic [CNT_FW-1:0] fifo_count;

  // injection gating and PE packet selection
  always_comb begin
    slot_live   = |i_source_lifetime;
    inject_room = (fifo_count <= CNT_FW'(FIFO_DEPTH - AF_MARGIN));
    local_ready = ~slot_live & i_inject_en & ~i_dispatcher_back_pressure & inject_room;
    accept      = bus.local_valid & local_ready;
    hit_push    = slot_live & i_hit;
    push        = hit_push | accept;
    push_data   = slot_live ? make_pos(i_source_offset_pkt, i_cid_x, i_cid_y, i_cid_z)
                            : make_pos(bus.local_offset_pkt, LCID, LCID, LCID);
    pop         = bus.pos_pkt_to_pe_valid & bus.pe_ready;
    drop        = push & fifo_full & ~pop;
  end

  assign bus.local_ready = local_ready;
  assign o_fifo_count    = fifo_count;

  // ring slot register: forward live slots, fill empty slots on injection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_offset_pkt_to_ring <= '0;
      o_gcid_to_ring       <= '0;
      o_lifetime_to_ring   <= '0;
    end else if (slot_live) begin
      o_offset_pkt_to_ring <= i_source_offset_pkt;
      o_gcid_to_ring       <= i_source_gcid;
      o_lifetime_to_ring   <= i_hit ? i_source_lifetime - LIFETIME_W'(1) : i_source_lifetime;
    end else if (accept) begin
      o_offset_pkt_to_ring <= bus.local_offset_pkt;
      o_gcid_to_ring       <= bus.local_gcid;
      o_lifetime_to_ring   <= LIFETIME_W'(INJECT_LIFETIME);
    end else begin
      o_lifetime_to_ring   <= '0;
    end
  end

  // saturating statistics and sticky overflow flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_hit_count  <= '0;
      o_drop_count <= '0;
      o_overflow   <= 1'b0;
    end else begin
      if (hit_push && !(&o_hit_count)) o_hit_count <= o_hit_count + CNT_W'(1);
      if (drop) begin
        if (!(&o_drop_count)) o_drop_count <= o_drop_count + CNT_W'(1);
        o_overflow <= 1'b1;
      end
    end
  end

  pos_pe_fifo #(
    .WIDTH (POS_W),
    .DEPTH (FIFO_DEPTH)
  ) u_pe_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_data),
    .pop       (bus.pe_ready),
    .pop_data  (bus.pos_pkt_to_pe),
    .valid     (bus.pos_pkt_to_pe_valid),
    .full      (fifo_full),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_pos_ring_node_router_fifo.sv
// Bench for the position-ring node router: directed cases plus a random
// phase, with PE packets checked against an expected queue.
module tb_pos_ring_node_router_fifo;
  import pos_ring_node_router_fifo_pkg::*;

  localparam int OW    = DEF_OFFSET_W;
  localparam int PKT_W = DEF_PKT_W;
  localparam int POS_W = DEF_POS_W;
  localparam int GW    = 3 * DEF_GCID_W;
  localparam int TAILW = DEF_ELEMENT_W + DEF_PID_W;
  localparam int ROOM  = DEF_FIFO_DEPTH - DEF_AF_MARGIN;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic             i_hit;
  logic             i_dispatcher_back_pressure;
  logic             i_inject_en;
  logic [PKT_W-1:0] i_source_offset_pkt;
  logic [GW-1:0]    i_source_gcid;
  logic [3:0]       i_source_lifetime;
  logic [2:0]       i_cid_x, i_cid_y, i_cid_z;
  logic [PKT_W-1:0] o_offset_pkt_to_ring;
  logic [GW-1:0]    o_gcid_to_ring;
  logic [3:0]       o_lifetime_to_ring;
  logic [4:0]       o_fifo_count;
  logic [15:0]      o_hit_count, o_drop_count;
  logic             o_overflow;

  pos_ring_node_router_fifo_if bus ();

  pos_ring_node_router_fifo dut (
    .clk                        (clk),
    .rst_n                      (rst_n),
    .i_hit                      (i_hit),
    .i_dispatcher_back_pressure (i_dispatcher_back_pressure),
    .i_inject_en                (i_inject_en),
    .i_source_offset_pkt        (i_source_offset_pkt),
    .i_source_gcid              (i_source_gcid),
    .i_source_lifetime          (i_source_lifetime),
    .i_cid_x                    (i_cid_x),
    .i_cid_y                    (i_cid_y),
    .i_cid_z                    (i_cid_z),
    .bus                        (bus),
    .o_offset_pkt_to_ring       (o_offset_pkt_to_ring),
    .o_gcid_to_ring             (o_gcid_to_ring),
    .o_lifetime_to_ring         (o_lifetime_to_ring),
    .o_fifo_count               (o_fifo_count),
    .o_hit_count                (o_hit_count),
    .o_drop_count               (o_drop_count),
    .o_overflow                 (o_overflow)
  );

  // scoreboard state
  logic [POS_W-1:0] exp_q[$];
  int               n_checks = 0;
  int               n_pass   = 0;
  int               mdl_count;
  int               mdl_hits;
  int               mdl_drops;
  bit               mdl_ovf;
  logic [PKT_W-1:0] mdl_pkt;
  logic [GW-1:0]    mdl_gcid;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic logic [PKT_W-1:0] rand_pkt();
    logic [95:0] r;
    r = {$urandom, $urandom, $urandom};
    return r[PKT_W-1:0];
  endfunction

  // reference packing: {pid,elem} | cz,z | cy,y | cx,x
  function automatic logic [POS_W-1:0] build_pos(input logic [PKT_W-1:0] p,
                                                 input logic [2:0] cx, input logic [2:0] cy,
                                                 input logic [2:0] cz);
    return {p[PKT_W-1:PKT_W-TAILW], cz, p[3*OW-1:2*OW], cy, p[2*OW-1:OW], cx, p[OW-1:0]};
  endfunction

  task automatic model_reset();
    exp_q.delete();
    mdl_count = 0;
    mdl_hits  = 0;
    mdl_drops = 0;
    mdl_ovf   = 0;
    mdl_pkt   = '0;
    mdl_gcid  = '0;
  endtask

  // driver: one clock of stimulus, entered and left at posedge+1
  task automatic step(input int lt, input bit hit, input logic [2:0] cx, input logic [2:0] cy,
                      input logic [2:0] cz, input bit lv, input bit en, input bit bp,
                      input bit pe_rdy);
    logic [PKT_W-1:0] sp, lp;
    logic [GW-1:0]    sg, lg;
    bit               exp_ready, live, acc, do_push, do_pop;
    int               exp_lt;
    sp = rand_pkt();
    lp = rand_pkt();
    sg = GW'($urandom);
    lg = GW'($urandom);
    #1;
    i_source_lifetime          = 4'(lt);
    i_hit                      = hit;
    i_cid_x                    = cx;
    i_cid_y                    = cy;
    i_cid_z                    = cz;
    i_source_offset_pkt        = sp;
    i_source_gcid              = sg;
    i_inject_en                = en;
    i_dispatcher_back_pressure = bp;
    bus.local_offset_pkt       = lp;
    bus.local_gcid             = lg;
    bus.local_valid            = lv;
    bus.pe_ready               = pe_rdy;
    #1;
    live      = (lt != 0);
    exp_ready = !live && en && !bp && (mdl_count <= ROOM);
    check("local_ready", bus.local_ready, exp_ready);
    acc     = lv && exp_ready;
    do_push = (live && hit) || acc;
    do_pop  = pe_rdy && (mdl_count > 0);
    if (live) begin
      mdl_pkt  = sp;
      mdl_gcid = sg;
      exp_lt   = hit ? lt - 1 : lt;
      if (hit && mdl_hits < 65535) mdl_hits++;
    end else if (acc) begin
      mdl_pkt  = lp;
      mdl_gcid = lg;
      exp_lt   = DEF_INJECT_LIFETIME;
    end else begin
      exp_lt   = 0;
    end
    if (do_push) begin
      if (mdl_count < DEF_FIFO_DEPTH || do_pop) begin
        exp_q.push_back(live ? build_pos(sp, cx, cy, cz)
                             : build_pos(lp, 3'(DEF_LOCAL_CID), 3'(DEF_LOCAL_CID), 3'(DEF_LOCAL_CID)));
        mdl_count++;
      end else begin
        if (mdl_drops < 65535) mdl_drops++;
        mdl_ovf = 1;
      end
    end
    if (do_pop) mdl_count--;
    @(posedge clk);
    #1;
    check("ring_lifetime", o_lifetime_to_ring, exp_lt);
    check("ring_pkt", o_offset_pkt_to_ring, mdl_pkt);
    check("ring_gcid", o_gcid_to_ring, mdl_gcid);
    check("fifo_count", o_fifo_count, mdl_count);
    check("pe_valid", bus.pos_pkt_to_pe_valid, mdl_count > 0);
    check("hit_count", o_hit_count, mdl_hits);
    check("drop_count", o_drop_count, mdl_drops);
    check("overflow", o_overflow, mdl_ovf);
  endtask

  // scoreboard consumer: compare the FIFO head on every PE handshake
  always @(negedge clk) begin
    if (rst_n && bus.pos_pkt_to_pe_valid && bus.pe_ready) begin
      if (exp_q.size() == 0) check("pe_unexpected", bus.pos_pkt_to_pe_valid, 1'b0);
      else check("pe_pkt", bus.pos_pkt_to_pe, exp_q.pop_front());
    end
  end

  // watchdog
  initial begin
    #300000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    rst_n                      = 1'b0;
    i_hit                      = 1'b0;
    i_dispatcher_back_pressure = 1'b0;
    i_inject_en                = 1'b0;
    i_source_offset_pkt        = '0;
    i_source_gcid              = '0;
    i_source_lifetime          = '0;
    i_cid_x                    = '0;
    i_cid_y                    = '0;
    i_cid_z                    = '0;
    bus.local_offset_pkt       = '0;
    bus.local_gcid             = '0;
    bus.local_valid            = 1'b0;
    bus.pe_ready               = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_lifetime", o_lifetime_to_ring, 0);
    check("rst_ring_pkt", o_offset_pkt_to_ring, 0);
    check("rst_count", o_fifo_count, 0);
    check("rst_valid", bus.pos_pkt_to_pe_valid, 0);
    check("rst_pe_pkt", bus.pos_pkt_to_pe, 0);
    check("rst_overflow", o_overflow, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // injection into an empty slot, then delivery with local cid 2/2/2
    step(0, 0, 0, 0, 0, 1, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 0, 1);
    // live slot hit with cid (1,3,0)
    step(5, 1, 3'd1, 3'd3, 3'd0, 1, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 0, 1);
    // live slot no hit: forwarded unchanged, injection blocked
    step(5, 0, 3'd4, 3'd4, 3'd4, 1, 1, 0, 0);
    // back-pressure and disable block injection
    step(0, 0, 0, 0, 0, 1, 1, 1, 0);
    step(0, 0, 0, 0, 0, 1, 0, 0, 0);
    // fill by injection until the almost-full margin stops it
    for (int i = 0; i < ROOM + 2; i++) step(0, 0, 0, 0, 0, 1, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 0, 1);
    step(0, 0, 0, 0, 0, 1, 1, 0, 0);
    // hits fill to full, then drop, then push+pop at full
    for (int i = 0; i < DEF_AF_MARGIN - 1; i++) step(5, 1, 3'd1, 3'd2, 3'd3, 0, 1, 0, 0);
    step(7, 1, 3'd5, 3'd6, 3'd7, 0, 1, 0, 0);
    step(7, 1, 3'd2, 3'd1, 3'd0, 0, 1, 0, 1);
    for (int i = 0; i < DEF_FIFO_DEPTH + 2; i++) step(0, 0, 0, 0, 0, 0, 1, 0, 1);

    // random traffic
    for (int i = 0; i < 120; i++) begin
      step($urandom_range(0, 1) ? 0 : $urandom_range(1, 15), 1'($urandom_range(0, 1)),
           3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
           1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 7) != 0),
           1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 2) == 0));
    end
    for (int i = 0; i < DEF_FIFO_DEPTH + 2; i++) step(0, 0, 0, 0, 0, 0, 1, 0, 1);
    check("sb_drain", exp_q.size(), 0);

    // asynchronous reset in the middle of a burst
    for (int i = 0; i < 7; i++) step(0, 0, 0, 0, 0, 1, 1, 0, 0);
    check("pre_rst_count", o_fifo_count, 7);
    #1;
    bus.local_valid = 1'b0;
    rst_n           = 1'b0;
    #1;
    check("mid_rst_count", o_fifo_count, 0);
    check("mid_rst_valid", bus.pos_pkt_to_pe_valid, 0);
    check("mid_rst_pe_pkt", bus.pos_pkt_to_pe, 0);
    check("mid_rst_lifetime", o_lifetime_to_ring, 0);
    check("mid_rst_ring_pkt", o_offset_pkt_to_ring, 0);
    check("mid_rst_hits", o_hit_count, 0);
    check("mid_rst_drops", o_drop_count, 0);
    check("mid_rst_overflow", o_overflow, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step(0, 0, 0, 0, 0, 1, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 0, 1);
    check("final_drain", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
